// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole game: sequencer state encoding and
// default mole-period constants used by the sequencer and display controller.
package mole_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEED = 3'd1,
    PLAY = 3'd2,
    HIT  = 3'd3,
    OVER = 3'd4
  } state_t;

  localparam logic [27:0] BASE_SPEED = 28'd50_000_000;
  localparam logic [27:0] SPEED_STEP = 28'd5_000_000;
  localparam logic [27:0] MIN_SPEED  = 28'd10_000_000;

endpackage

// File: rtl/mole_game_sequencer_rise_detect.sv
// One-bit rising-edge detector: the input is registered once and an edge is
// reported while the registered value is 1 and its previous value was 0.
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic i_in,
  output logic o_rise
);

  logic r_cur;
  logic r_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cur  <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_cur  <= i_in;
      r_prev <= r_cur;
    end
  end

  assign o_rise = r_cur & ~r_prev;

endmodule

// File: rtl/mole_game_sequencer.sv
// Game FSM for the three-mole whack-a-mole: sequences the display controller,
// classifies key presses against the lit mole, and tracks score/misses/level.
module mole_game_sequencer #(
  parameter logic [27:0] BASE_SPEED     = mole_pkg::BASE_SPEED,
  parameter logic [27:0] SPEED_STEP     = mole_pkg::SPEED_STEP,
  parameter logic [27:0] MIN_SPEED      = mole_pkg::MIN_SPEED,
  parameter int unsigned HITS_PER_LEVEL = 5,
  parameter int unsigned MAX_MISSES     = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  key,
  input  logic [2:0]  mole,
  output logic        game,
  output logic        turnoff,
  output logic [27:0] speed,
  output logic [1:0]  seed,
  output logic [7:0]  score,
  output logic [3:0]  misses,
  output logic [3:0]  level,
  output logic        game_over,
  output logic [2:0]  dbg_state
);

  import mole_pkg::*;

  state_t      r_state;
  state_t      w_next;
  logic        w_start_edge;
  logic [2:0]  w_key_edge;
  logic        w_hit;
  logic        w_miss;
  logic [3:0]  w_misses_inc;
  logic [7:0]  w_hit_inc;
  logic        w_level_up;
  logic [28:0] w_floor;
  logic [27:0] w_speed_dn;

  logic        r_game;
  logic        r_turnoff;
  logic        r_game_over;
  logic [27:0] r_speed;
  logic [1:0]  r_seed;
  logic [1:0]  r_seed_cnt;
  logic [7:0]  r_score;
  logic [3:0]  r_misses;
  logic [3:0]  r_level;
  logic [7:0]  r_hit_cnt;

  rise_detect u_rise_start (
    .clock (clock), .reset (reset), .i_in (start), .o_rise (w_start_edge)
  );

  for (genvar g = 0; g < 3; g++) begin : g_key_rise
    rise_detect u_rise_key (
      .clock (clock), .reset (reset), .i_in (key[g]), .o_rise (w_key_edge[g])
    );
  end

  assign w_misses_inc = r_misses + 4'd1;
  assign w_hit_inc    = r_hit_cnt + 8'd1;
  assign w_level_up   = (w_hit_inc == 8'(HITS_PER_LEVEL));
  // Compare in 29 bits so MIN_SPEED + SPEED_STEP cannot overflow.
  assign w_floor      = {1'b0, MIN_SPEED} + {1'b0, SPEED_STEP};
  assign w_speed_dn   = ({1'b0, r_speed} < w_floor) ? MIN_SPEED : (r_speed - SPEED_STEP);

  always_comb begin
    w_next = r_state;
    w_hit  = 1'b0;
    w_miss = 1'b0;
    case (r_state)
      IDLE, OVER: if (w_start_edge) w_next = SEED;
      SEED:       w_next = PLAY;
      PLAY: begin
        if (w_start_edge) begin
          w_next = SEED;
        end else if (|w_key_edge) begin
          if ($onehot(w_key_edge) && |(w_key_edge & mole)) begin
            w_hit  = 1'b1;
            w_next = HIT;
          end else begin
            w_miss = 1'b1;
            if (w_misses_inc == 4'(MAX_MISSES)) w_next = OVER;
          end
        end
      end
      HIT:        w_next = PLAY;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_game      <= 1'b0;
      r_turnoff   <= 1'b0;
      r_game_over <= 1'b0;
      r_speed     <= BASE_SPEED;
      r_seed      <= 2'b01;
      r_seed_cnt  <= 2'b01;
      r_score     <= 8'd0;
      r_misses    <= 4'd0;
      r_level     <= 4'd0;
      r_hit_cnt   <= 8'd0;
    end else begin
      r_seed_cnt  <= (r_seed_cnt == 2'b11) ? 2'b01 : (r_seed_cnt + 2'b01);
      r_game      <= (w_next == PLAY) || (w_next == HIT);
      r_turnoff   <= (w_next == HIT);
      r_game_over <= (w_next == OVER);
      if (r_state == SEED) begin
        r_seed    <= r_seed_cnt;
        r_score   <= 8'd0;
        r_misses  <= 4'd0;
        r_level   <= 4'd0;
        r_hit_cnt <= 8'd0;
        r_speed   <= BASE_SPEED;
      end
      if (w_hit) begin
        if (r_score != 8'hFF) r_score <= r_score + 8'd1;
        if (w_level_up) begin
          r_hit_cnt <= 8'd0;
          if (r_level != 4'hF) r_level <= r_level + 4'd1;
          r_speed <= w_speed_dn;
        end else begin
          r_hit_cnt <= w_hit_inc;
        end
      end
      if (w_miss) r_misses <= w_misses_inc;
    end
  end

  assign game      = r_game;
  assign turnoff   = r_turnoff;
  assign game_over = r_game_over;
  assign speed     = r_speed;
  assign seed      = r_seed;
  assign score     = r_score;
  assign misses    = r_misses;
  assign level     = r_level;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mole_game_sequencer.sv
// Drives two sequencer instances (default and small-period configurations)
// with identical directed and random stimulus against a game-rule model.
module tb_mole_game_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  key;
  logic [2:0]  mole;

  logic        game0, turnoff0, game_over0, game1, turnoff1, game_over1;
  logic [27:0] speed0, speed1;
  logic [1:0]  seed0, seed1;
  logic [7:0]  score0, score1;
  logic [3:0]  misses0, misses1, level0, level1;
  logic [2:0]  dbg0, dbg1;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mole_game_sequencer u_dut0 (
    .clock (clock), .reset (reset), .start (start), .key (key), .mole (mole),
    .game (game0), .turnoff (turnoff0), .speed (speed0), .seed (seed0),
    .score (score0), .misses (misses0), .level (level0),
    .game_over (game_over0), .dbg_state (dbg0)
  );

  mole_game_sequencer #(
    .BASE_SPEED (28'd30), .SPEED_STEP (28'd15), .MIN_SPEED (28'd10),
    .HITS_PER_LEVEL (2), .MAX_MISSES (3)
  ) u_dut1 (
    .clock (clock), .reset (reset), .start (start), .key (key), .mole (mole),
    .game (game1), .turnoff (turnoff1), .speed (speed1), .seed (seed1),
    .score (score1), .misses (misses1), .level (level1),
    .game_over (game_over1), .dbg_state (dbg1)
  );

  // Game-rule reference model, one copy per configuration.
  longint c_base[2] = '{50_000_000, 30};
  longint c_step[2] = '{5_000_000, 15};
  longint c_min[2]  = '{10_000_000, 10};
  int     c_hpl[2]  = '{5, 2};
  int     c_maxm[2] = '{3, 3};

  string  m_mode[2];
  int     m_score[2], m_misses[2], m_level[2], m_hits[2];
  longint m_speed[2];
  logic   st_cur, st_prev;
  logic [2:0] k_cur, k_prev;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = "idle"; m_score[d] = 0; m_misses[d] = 0;
      m_level[d] = 0; m_hits[d] = 0; m_speed[d] = c_base[d];
    end
    st_cur = 0; st_prev = 0; k_cur = 0; k_prev = 0;
  endtask

  task automatic model_tick();
    logic       s_e;
    logic [2:0] k_e;
    s_e = st_cur & ~st_prev;
    k_e = k_cur & ~k_prev;
    for (int d = 0; d < 2; d++) begin
      if (m_mode[d] == "idle" || m_mode[d] == "over") begin
        if (s_e) m_mode[d] = "seed";
      end else if (m_mode[d] == "seed") begin
        m_score[d] = 0; m_misses[d] = 0; m_level[d] = 0; m_hits[d] = 0;
        m_speed[d] = c_base[d]; m_mode[d] = "play";
      end else if (m_mode[d] == "hit") begin
        m_mode[d] = "play";
      end else if (s_e) begin
        m_mode[d] = "seed";
      end else if (k_e != 3'b000) begin
        if ($countones(k_e) == 1 && (k_e & mole) != 3'b000) begin
          m_score[d] = (m_score[d] < 255) ? m_score[d] + 1 : 255;
          m_hits[d]++;
          if (m_hits[d] == c_hpl[d]) begin
            m_hits[d] = 0;
            m_level[d] = (m_level[d] < 15) ? m_level[d] + 1 : 15;
            m_speed[d] = (m_speed[d] - c_step[d] < c_min[d]) ? c_min[d] : m_speed[d] - c_step[d];
          end
          m_mode[d] = "hit";
        end else begin
          m_misses[d]++;
          if (m_misses[d] == c_maxm[d]) m_mode[d] = "over";
        end
      end
    end
    st_prev = st_cur; st_cur = start; k_prev = k_cur; k_cur = key;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_dut(input int d, input logic g, input logic t, input logic go,
                           input logic [27:0] sp, input logic [1:0] sd, input logic [7:0] sc,
                           input logic [3:0] mi, input logic [3:0] lv);
    string p;
    p = (d == 0) ? "d0" : "d1";
    check({p, "_game"}, 32'(g), 32'(m_mode[d] == "play" || m_mode[d] == "hit"));
    check({p, "_turnoff"}, 32'(t), 32'(m_mode[d] == "hit"));
    check({p, "_game_over"}, 32'(go), 32'(m_mode[d] == "over"));
    check({p, "_speed"}, 32'(sp), 32'(m_speed[d]));
    check({p, "_seed_nonzero"}, 32'(sd != 2'b00), 32'd1);
    check({p, "_score"}, 32'(sc), 32'(m_score[d]));
    check({p, "_misses"}, 32'(mi), 32'(m_misses[d]));
    check({p, "_level"}, 32'(lv), 32'(m_level[d]));
  endtask

  task automatic step();
    if (reset) model_reset();
    else       model_tick();
    @(posedge clock);
    #1;
    check_dut(0, game0, turnoff0, game_over0, speed0, seed0, score0, misses0, level0);
    check_dut(1, game1, turnoff1, game_over1, speed1, seed1, score1, misses1, level1);
  endtask

  task automatic press(input logic [2:0] mask);
    key = mask; step();
    key = 3'b000; step(); step(); step();
  endtask

  task automatic pulse_start();
    start = 1'b1; step();
    start = 1'b0; step(); step(); step();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; key = 3'b000; mole = 3'b000;
    step(); step();
    check("d0_state_idle", 32'(dbg0), 32'(mole_pkg::IDLE));
    reset = 1'b0;
    step();

    // Game start, one hit, then misses until game over.
    pulse_start();
    mole = 3'b010; press(3'b010);
    mole = 3'b001; press(3'b100); press(3'b011); press(3'b100);
    step(); step();

    // Restart and run hits through level-ups and the speed floor.
    pulse_start();
    mole = 3'b001;
    for (int i = 0; i < 6; i++) press(3'b001);

    // Second key rises while in HIT: ignored.
    mole = 3'b010;
    key = 3'b010; step();
    key = 3'b011; step();
    key = 3'b000; step(); step(); step();

    // Start edge together with a key edge in PLAY.
    mole = 3'b100;
    start = 1'b1; key = 3'b100; step();
    start = 1'b0; key = 3'b000; step(); step(); step();

    // Reset while in HIT.
    press(3'b100);
    key = 3'b100; step(); key = 3'b000; step();
    check("d1_turnoff_before_reset", 32'(turnoff1), 32'd1);
    reset = 1'b1; step();
    check("d0_state_idle_after_reset", 32'(dbg0), 32'(mole_pkg::IDLE));
    check("d1_state_idle_after_reset", 32'(dbg1), 32'(mole_pkg::IDLE));
    reset = 1'b0; step();

    // Random play.
    pulse_start();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) key = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) mole = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) start = ~start;
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
